// File: rtl/y86_pkg.sv
// Y86-64 instruction codes and PC-predictor state encoding shared by the
// fetch-side PC logic.
package y86_pkg;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } pc_state_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, push on full overwrites the oldest entry.
// Top is valid one cycle after push; pop on empty is ignored.
module pc_ras #(
   parameter int PC_W      = 11,
   parameter int RAS_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [PC_W-1:0]            push_dat_i,
   output logic [PC_W-1:0]            top_o,
   output logic [$clog2(RAS_DEPTH):0] count_o
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int unsigned FULL = RAS_DEPTH;

   logic [PC_W-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW:0]     cnt_q, cnt_d;

   // ptr_q points at the next free slot; count saturates so it never wraps
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push_i) begin
         ptr_d = ptr_q + 1'b1;
         if (cnt_q != FULL[PW:0]) cnt_d = cnt_q + 1'b1;
      end else if (pop_i && (cnt_q != '0)) begin
         ptr_d = ptr_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push_i) mem_q[ptr_q] <= push_dat_i;
   end

   assign top_o   = mem_q[ptr_q - 1'b1];
   assign count_o = cnt_q;

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with next-PC prediction (fall-through, jXX/call target, RAS for ret).
// Latency 1 cycle, all outputs registered; stall holds PC/RAS, redirect overrides stall.
module pc_predict_unit
   import y86_pkg::*;
#(
   parameter int              PC_W      = 11,
   parameter int              RAS_DEPTH = 8,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int              JXX_TAKEN = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       f_valid,
   input  logic [3:0]                 f_icode,
   input  logic [63:0]                f_valC,
   input  logic [PC_W-1:0]            f_valP,
   input  logic                       stall,
   input  logic                       redir_valid,
   input  logic [63:0]                redir_pc,
   output logic [PC_W-1:0]            pc,
   output logic                       halted,
   output logic                       bad_icode,
   output logic [$clog2(RAS_DEPTH):0] ras_count,
   output logic                       ras_miss
);

   pc_state_t       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            bad_q, bad_d;
   logic            miss_q, miss_d;
   logic            ras_push, ras_pop;
   logic [PC_W-1:0] ras_top;

   // Upper address bits are architecturally dropped; PC space is PC_W bits
   logic unused_hi;
   assign unused_hi = ^{f_valC[63:PC_W], redir_pc[63:PC_W]};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      bad_d    = bad_q;
      miss_d   = 1'b0;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      if (redir_valid) begin
         pc_d    = redir_pc[PC_W-1:0];
         state_d = ST_RUN;
      end else if (!stall && f_valid && (state_q == ST_RUN)) begin
         case (f_icode)
            ICODE_NOP, ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_RMMOVQ,
            ICODE_MRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: pc_d = f_valP;
            ICODE_JXX:  pc_d = (JXX_TAKEN != 0) ? f_valC[PC_W-1:0] : f_valP;
            ICODE_CALL: begin
               pc_d     = f_valC[PC_W-1:0];
               ras_push = 1'b1;
            end
            ICODE_RET: begin
               if (ras_count == '0) begin
                  pc_d   = f_valP;
                  miss_d = 1'b1;
               end else begin
                  pc_d    = ras_top;
                  ras_pop = 1'b1;
               end
            end
            ICODE_HALT: state_d = ST_HALT;
            default: begin
               state_d = ST_HALT;
               bad_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         bad_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         bad_q   <= bad_d;
         miss_q  <= miss_d;
      end
   end

   pc_ras #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (ras_push),
      .pop_i      (ras_pop),
      .push_dat_i (f_valP),
      .top_o      (ras_top),
      .count_o    (ras_count)
   );

   assign pc        = pc_q;
   assign halted    = (state_q == ST_HALT);
   assign bad_icode = bad_q;
   assign ras_miss  = miss_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Vector table of per-cycle stimulus and hand-derived expected outputs,
// checked through a scoreboard queue one cycle after each drive.
module tb_pc_predict_unit;

   localparam int PC_W      = 11;
   localparam int RAS_DEPTH = 8;
   localparam int CW        = $clog2(RAS_DEPTH) + 1;

   typedef struct {
      logic [63:0]     tag;
      logic            rst_n;
      logic            f_valid;
      logic [3:0]      icode;
      logic [63:0]     valc;
      logic [PC_W-1:0] valp;
      logic            stall;
      logic            rv;
      logic [63:0]     rpc;
      logic [PC_W-1:0] e_pc;
      logic            e_halt;
      logic            e_bad;
      logic [CW-1:0]   e_cnt;
      logic            e_miss;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            f_valid;
   logic [3:0]      f_icode;
   logic [63:0]     f_valC;
   logic [PC_W-1:0] f_valP;
   logic            stall;
   logic            redir_valid;
   logic [63:0]     redir_pc;
   logic [PC_W-1:0] pc;
   logic            halted;
   logic            bad_icode;
   logic [CW-1:0]   ras_count;
   logic            ras_miss;

   int vectors    = 0;
   int miscompares = 0;

   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   pc_predict_unit #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH),
      .RESET_PC  ('0),
      .JXX_TAKEN (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .f_valid     (f_valid),
      .f_icode     (f_icode),
      .f_valC      (f_valC),
      .f_valP      (f_valP),
      .stall       (stall),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .pc          (pc),
      .halted      (halted),
      .bad_icode   (bad_icode),
      .ras_count   (ras_count),
      .ras_miss    (ras_miss)
   );

   function automatic vec_t mk(input logic [63:0] tag, input logic rs, input logic fv,
                               input logic [3:0] ic, input logic [63:0] vc,
                               input logic [PC_W-1:0] vp, input logic st, input logic rv,
                               input logic [63:0] rp, input logic [PC_W-1:0] epc,
                               input logic eh, input logic eb, input logic [CW-1:0] ec,
                               input logic em);
      vec_t v;
      v.tag = tag; v.rst_n = rs; v.f_valid = fv; v.icode = ic; v.valc = vc;
      v.valp = vp; v.stall = st; v.rv = rv; v.rpc = rp;
      v.e_pc = epc; v.e_halt = eh; v.e_bad = eb; v.e_cnt = ec; v.e_miss = em;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst_n       = v.rst_n;
      f_valid     = v.f_valid;
      f_icode     = v.icode;
      f_valC      = v.valc;
      f_valP      = v.valp;
      stall       = v.stall;
      redir_valid = v.rv;
      redir_pc    = v.rpc;
   endtask

   task automatic check_one();
      vec_t e;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: no expected entry for DUT output");
         return;
      end
      e = sb.pop_front();
      vectors++;
      if (pc !== e.e_pc || halted !== e.e_halt || bad_icode !== e.e_bad ||
          ras_count !== e.e_cnt || ras_miss !== e.e_miss) begin
         miscompares++;
         $display("FAIL %0s: got pc=%h halted=%b bad=%b cnt=%0d miss=%b, want pc=%h halted=%b bad=%b cnt=%0d miss=%b",
                  e.tag, pc, halted, bad_icode, ras_count, ras_miss,
                  e.e_pc, e.e_halt, e.e_bad, e.e_cnt, e.e_miss);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      drive(v);
      sb.push_back(v);
      @(posedge clk);
      #1;
      check_one();
   endtask

   initial begin
      rst_n = 1'b0; f_valid = 1'b0; f_icode = '0; f_valC = '0; f_valP = '0;
      stall = 1'b0; redir_valid = 1'b0; redir_pc = '0;

      // reset
      tbl.push_back(mk("rst0",   0,0,4'h0,64'h0,11'h0,0,0,64'h0, 11'h000,0,0,4'd0,0));
      tbl.push_back(mk("rst1",   0,0,4'h0,64'h0,11'h0,0,0,64'h0, 11'h000,0,0,4'd0,0));
      // sequential fall-through
      tbl.push_back(mk("opq",    1,1,4'h6,64'h0,11'h0A,0,0,64'h0, 11'h00A,0,0,4'd0,0));
      tbl.push_back(mk("irmov",  1,1,4'h3,64'h0,11'h14,0,0,64'h0, 11'h014,0,0,4'd0,0));
      tbl.push_back(mk("idle",   1,0,4'h6,64'h0,11'h77,0,0,64'h0, 11'h014,0,0,4'd0,0));
      tbl.push_back(mk("jxx",    1,1,4'h7,64'hFFFF_0000_0000_0255,11'h1E,0,0,64'h0, 11'h255,0,0,4'd0,0));
      // call / ret
      tbl.push_back(mk("call",   1,1,4'h8,64'h40,11'h09,0,0,64'h0, 11'h040,0,0,4'd1,0));
      tbl.push_back(mk("ret",    1,1,4'h9,64'h0,11'h77,0,0,64'h0, 11'h009,0,0,4'd0,0));
      // overflow: 9 calls into an 8-deep stack
      for (int i = 1; i <= 9; i++)
         tbl.push_back(mk("ovf_call",1,1,4'h8,64'(32'h100 + i),11'(i),0,0,64'h0,
                          11'(32'h100 + i),0,0,CW'((i > 8) ? 8 : i),0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk("ovf_ret",1,1,4'h9,64'h0,11'h50,0,0,64'h0,
                          11'(9 - i),0,0,CW'(7 - i),0));
      tbl.push_back(mk("ret_miss",1,1,4'h9,64'h0,11'h33,0,0,64'h0, 11'h033,0,0,4'd0,1));
      tbl.push_back(mk("miss_clr",1,0,4'h0,64'h0,11'h0,0,0,64'h0,  11'h033,0,0,4'd0,0));
      // priority
      tbl.push_back(mk("stall",  1,1,4'h8,64'h60,11'h34,1,0,64'h0, 11'h033,0,0,4'd0,0));
      tbl.push_back(mk("st_redir",1,1,4'h8,64'h60,11'h34,1,1,64'h100, 11'h100,0,0,4'd0,0));
      tbl.push_back(mk("redir_tr",1,0,4'h0,64'h0,11'h0,0,1,64'hABCD_0000_0000_0F0F, 11'h70F,0,0,4'd0,0));
      // halt / recover
      tbl.push_back(mk("halt",   1,1,4'h0,64'h0,11'h12,0,0,64'h0, 11'h70F,1,0,4'd0,0));
      tbl.push_back(mk("h_fetch",1,1,4'h6,64'h0,11'h10,0,0,64'h0, 11'h70F,1,0,4'd0,0));
      tbl.push_back(mk("h_call", 1,1,4'h8,64'h55,11'h11,0,0,64'h0, 11'h70F,1,0,4'd0,0));
      tbl.push_back(mk("h_redir",1,0,4'h0,64'h0,11'h0,0,1,64'h20, 11'h020,0,0,4'd0,0));
      tbl.push_back(mk("bad_f",  1,1,4'hF,64'h0,11'h25,0,0,64'h0, 11'h020,1,1,4'd0,0));
      tbl.push_back(mk("bad_stk",1,0,4'h0,64'h0,11'h0,0,0,64'h0,  11'h020,1,1,4'd0,0));
      tbl.push_back(mk("b_redir",1,0,4'h0,64'h0,11'h0,0,1,64'h30, 11'h030,0,1,4'd0,0));
      tbl.push_back(mk("b_call", 1,1,4'h8,64'h44,11'h31,0,0,64'h0, 11'h044,0,1,4'd1,0));
      tbl.push_back(mk("r_keep", 1,0,4'h0,64'h0,11'h0,0,1,64'h50, 11'h050,0,1,4'd1,0));
      tbl.push_back(mk("bad_c",  1,1,4'hC,64'h0,11'h52,0,0,64'h0, 11'h050,1,1,4'd1,0));
      tbl.push_back(mk("h_rst",  0,1,4'h6,64'h0,11'h60,0,1,64'h99, 11'h000,0,0,4'd0,0));
      tbl.push_back(mk("post_rst",1,1,4'h9,64'h0,11'h61,0,0,64'h0, 11'h061,0,0,4'd0,1));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // call then stalled ret: RAS must hold the return address across the stall
      apply(mk("s_call", 1,1,4'h8,64'h200,11'h0C,0,0,64'h0, 11'h200,0,0,4'd1,0));
      apply(mk("s_ret",  1,1,4'h9,64'h0,11'h7F,1,0,64'h0,   11'h200,0,0,4'd1,0));
      apply(mk("s_ret2", 1,1,4'h9,64'h0,11'h7F,0,0,64'h0,   11'h00C,0,0,4'd0,0));

      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_left: %0d entries unchecked, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
